// File: rtl/instr_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_pkg : shared widths, reset PC and fetch FSM state encodings
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package instr_fetch_unit_pkg;

  localparam int unsigned XLEN_DEF        = 32;
  localparam int unsigned PC_BITWIDTH_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t S_IDLE = 2'd0;
  localparam fetch_state_t S_REQ  = 2'd1;
  localparam fetch_state_t S_WAIT = 2'd2;
  localparam fetch_state_t S_HOLD = 2'd3;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if : instruction-memory read port and decode hand-off bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface instr_fetch_unit_if
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned XLEN        = XLEN_DEF,
  parameter int unsigned PC_BITWIDTH = PC_BITWIDTH_DEF
);

  logic                     mem_read_en;
  logic [PC_BITWIDTH-3:0]   mem_addr;
  logic                     mem_read_ack;
  logic [XLEN-1:0]          mem_data;

  logic                     enable_out;
  logic                     ready_in;
  logic [XLEN-1:0]          IR_out;
  logic [PC_BITWIDTH-1:0]   PC_out;

  // master is the fetch unit; slave is the memory plus decode side
  modport master (
    output mem_read_en, mem_addr, enable_out, IR_out, PC_out,
    input  mem_read_ack, mem_data, ready_in
  );

  modport slave (
    input  mem_read_en, mem_addr, enable_out, IR_out, PC_out,
    output mem_read_ack, mem_data, ready_in
  );

endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit : PC register, single-outstanding memory fetch, decode hand-off
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned            XLEN        = XLEN_DEF,
  parameter int unsigned            PC_BITWIDTH = PC_BITWIDTH_DEF,
  parameter logic [PC_BITWIDTH-1:0] RESET_PC    = PC_BITWIDTH'(RESET_PC_DEF)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sync_reset_i,
  input  logic                   fetch_init_i,
  input  logic [PC_BITWIDTH-1:0] start_addr_i,
  input  logic                   fetch_enable_i,
  input  logic                   jump_en_i,
  input  logic [PC_BITWIDTH-1:0] jump_addr_i,
  output logic                   exception_misaligned_o,
  output logic [PC_BITWIDTH-1:0] exception_addr_o,
  instr_fetch_unit_if.master     bus
);

  fetch_state_t             state_q, state_d;
  logic [PC_BITWIDTH-1:0]   pc_q, pc_d;
  logic                     discard_q, discard_d;
  logic                     halt_q, halt_d;
  logic                     en_q, en_d;
  logic [XLEN-1:0]          ir_q, ir_d;
  logic [PC_BITWIDTH-1:0]   pc_out_q, pc_out_d;
  logic                     exc_q, exc_d;
  logic [PC_BITWIDTH-1:0]   exc_addr_q, exc_addr_d;

  logic [PC_BITWIDTH-1:0]   w_init_target;
  logic [PC_BITWIDTH-1:0]   w_target;
  logic                     w_misaligned;
  logic                     w_redirect;
  logic                     w_handshake;
  logic                     w_in_flight;

  assign w_init_target = start_addr_i & ~PC_BITWIDTH'(3);
  assign w_target      = jump_en_i ? jump_addr_i : w_init_target;
  assign w_misaligned  = jump_en_i & (jump_addr_i[1:0] != 2'b00);
  assign w_redirect    = jump_en_i | fetch_init_i;
  assign w_handshake   = en_q & bus.ready_in;
  // a read whose ack has not arrived yet must be drained before a new request
  assign w_in_flight   = (state_q == S_WAIT) & ~bus.mem_read_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      discard_q  <= 1'b0;
      halt_q     <= 1'b0;
      en_q       <= 1'b0;
      ir_q       <= '0;
      pc_out_q   <= '0;
      exc_q      <= 1'b0;
      exc_addr_q <= '0;
    end else if (sync_reset_i) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      discard_q  <= 1'b0;
      halt_q     <= 1'b0;
      en_q       <= 1'b0;
      ir_q       <= '0;
      pc_out_q   <= '0;
      exc_q      <= 1'b0;
      exc_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      halt_q     <= halt_d;
      en_q       <= en_d;
      ir_q       <= ir_d;
      pc_out_q   <= pc_out_d;
      exc_q      <= exc_d;
      exc_addr_q <= exc_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    discard_d  = discard_q;
    halt_d     = halt_q;
    en_d       = en_q;
    ir_d       = ir_q;
    pc_out_d   = pc_out_q;
    exc_d      = 1'b0;
    exc_addr_d = exc_addr_q;

    if (w_misaligned) begin
      // park until the trap logic issues an aligned redirect
      exc_d      = 1'b1;
      exc_addr_d = jump_addr_i;
      en_d       = 1'b0;
      halt_d     = 1'b1;
      discard_d  = w_in_flight;
      state_d    = w_in_flight ? S_WAIT : S_IDLE;
    end else if (w_redirect) begin
      pc_d      = w_target;
      en_d      = 1'b0;
      halt_d    = 1'b0;
      discard_d = w_in_flight;
      state_d   = w_in_flight ? S_WAIT : S_REQ;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fetch_enable_i && !halt_q) state_d = S_REQ;
        end
        S_REQ: begin
          state_d = fetch_enable_i ? S_WAIT : S_IDLE;
        end
        S_WAIT: begin
          if (bus.mem_read_ack) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = halt_q ? S_IDLE : S_REQ;
            end else begin
              en_d     = 1'b1;
              ir_d     = bus.mem_data;
              pc_out_d = pc_q;
              state_d  = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (w_handshake) begin
            pc_d    = pc_q + PC_BITWIDTH'(4);
            en_d    = 1'b0;
            state_d = fetch_enable_i ? S_REQ : S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // a redirect in S_REQ would make the old PC stale, so suppress that request
  always_comb begin
    bus.mem_read_en = (state_q == S_REQ) && fetch_enable_i && !w_redirect;
    bus.mem_addr    = pc_q[PC_BITWIDTH-1:2];
  end

  assign bus.enable_out          = en_q;
  assign bus.IR_out              = ir_q;
  assign bus.PC_out              = pc_out_q;
  assign exception_misaligned_o  = exc_q;
  assign exception_addr_o        = exc_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit : directed self-checking bench with a variable-latency memory
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sync_reset;
  logic        fetch_init;
  logic [31:0] start_addr;
  logic        fetch_enable;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        exc;
  logic [31:0] exc_addr;

  int total = 0;
  int bad   = 0;

  int          lat  = 1;
  int          cnt  = 0;
  bit          pend = 1'b0;
  logic [29:0] paddr;

  logic [31:0] exp_addr [3] = '{32'h40, 32'h41, 32'h42};
  logic [31:0] exp_pc   [3] = '{32'h100, 32'h104, 32'h108};
  logic [31:0] exp_ir   [3] = '{32'hA500_0040, 32'hA500_0041, 32'hA500_0042};

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.XLEN(32), .PC_BITWIDTH(32)) bus ();

  instr_fetch_unit #(
    .XLEN        (32),
    .PC_BITWIDTH (32),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .sync_reset_i           (sync_reset),
    .fetch_init_i           (fetch_init),
    .start_addr_i           (start_addr),
    .fetch_enable_i         (fetch_enable),
    .jump_en_i              (jump_en),
    .jump_addr_i            (jump_addr),
    .exception_misaligned_o (exc),
    .exception_addr_o       (exc_addr),
    .bus                    (bus)
  );

  // memory: a request seen in cycle N is acked for one cycle in cycle N+lat
  // with data 0xA5000000 ^ word_address
  always @(negedge clk) begin
    if (bus.mem_read_ack) bus.mem_read_ack = 1'b0;
    if (pend) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        bus.mem_read_ack = 1'b1;
        bus.mem_data     = 32'hA500_0000 ^ {2'b00, paddr};
        pend             = 1'b0;
      end
    end
    if (bus.mem_read_en) begin
      pend  = 1'b1;
      cnt   = lat;
      paddr = bus.mem_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  initial begin
    reset_n          = 1'b0;
    sync_reset       = 1'b0;
    fetch_init       = 1'b0;
    start_addr       = 32'h0;
    fetch_enable     = 1'b0;
    jump_en          = 1'b0;
    jump_addr        = 32'h0;
    bus.ready_in     = 1'b0;
    bus.mem_read_ack = 1'b0;
    bus.mem_data     = 32'h0;

    adv; adv; smp;
    chk("rst_req",      {31'b0, bus.mem_read_en}, 32'h0);
    chk("rst_addr",     {2'b00, bus.mem_addr},    32'h0);
    chk("rst_en",       {31'b0, bus.enable_out},  32'h0);
    chk("rst_ir",       bus.IR_out,               32'h0);
    chk("rst_pc",       bus.PC_out,               32'h0);
    chk("rst_exc",      {31'b0, exc},             32'h0);
    chk("rst_exc_addr", exc_addr,                 32'h0);

    adv; reset_n = 1'b1; smp;

    // sequential fetch from 0x100 at latency 1, one instruction every 3 cycles
    adv; fetch_init = 1'b1; start_addr = 32'h100; fetch_enable = 1'b1; bus.ready_in = 1'b1; smp;
    chk("init_no_req", {31'b0, bus.mem_read_en}, 32'h0);
    for (int i = 1; i <= 9; i++) begin
      adv;
      if (i == 1) fetch_init = 1'b0;
      if (i == 9) bus.ready_in = 1'b0;
      smp;
      chk("seq_en",  {31'b0, bus.enable_out},  {31'b0, (i % 3) == 0});
      chk("seq_req", {31'b0, bus.mem_read_en}, {31'b0, (i % 3) == 1});
      if ((i % 3) == 1) chk("seq_addr", {2'b00, bus.mem_addr}, exp_addr[(i - 1) / 3]);
      if ((i % 3) == 0) begin
        chk("seq_pc", bus.PC_out, exp_pc[i / 3 - 1]);
        chk("seq_ir", bus.IR_out, exp_ir[i / 3 - 1]);
      end
    end

    // decode stalls: output held, no new request
    for (int k = 0; k < 4; k++) begin
      adv; smp;
      chk("stall_en",  {31'b0, bus.enable_out},  32'h1);
      chk("stall_pc",  bus.PC_out,               32'h108);
      chk("stall_ir",  bus.IR_out,               32'hA500_0042);
      chk("stall_req", {31'b0, bus.mem_read_en}, 32'h0);
    end
    adv; bus.ready_in = 1'b1; smp;
    chk("stall_last_en", {31'b0, bus.enable_out}, 32'h1);
    adv; smp;
    chk("post_stall_req",  {31'b0, bus.mem_read_en}, 32'h1);
    chk("post_stall_addr", {2'b00, bus.mem_addr},    32'h43);
    adv; smp;
    adv; smp;
    chk("post_stall_pc", bus.PC_out, 32'h10C);
    chk("post_stall_ir", bus.IR_out, 32'hA500_0043);

    // redirect to 0x200 while a latency-4 read is outstanding
    adv; lat = 4; smp;
    chk("lat4_addr", {2'b00, bus.mem_addr}, 32'h44);
    adv; jump_en = 1'b1; jump_addr = 32'h200; smp;
    for (int k = 0; k < 3; k++) begin
      adv;
      if (k == 0) jump_en = 1'b0;
      smp;
      chk("drain_en",  {31'b0, bus.enable_out},  32'h0);
      chk("drain_req", {31'b0, bus.mem_read_en}, 32'h0);
    end
    adv; smp;
    chk("redir_req",  {31'b0, bus.mem_read_en}, 32'h1);
    chk("redir_addr", {2'b00, bus.mem_addr},    32'h80);
    for (int k = 0; k < 4; k++) begin
      adv; smp;
      chk("redir_wait_en", {31'b0, bus.enable_out}, 32'h0);
    end
    adv; smp;
    chk("redir_en", {31'b0, bus.enable_out}, 32'h1);
    chk("redir_pc", bus.PC_out,              32'h200);
    chk("redir_ir", bus.IR_out,              32'hA500_0080);

    // misaligned redirect while holding an instruction
    adv; lat = 1; smp;
    chk("mis_pre_addr", {2'b00, bus.mem_addr}, 32'h81);
    adv; smp;
    adv; bus.ready_in = 1'b0; jump_en = 1'b1; jump_addr = 32'h202; smp;
    chk("mis_hold_pc", bus.PC_out, 32'h204);
    adv; jump_en = 1'b0; bus.ready_in = 1'b1; smp;
    chk("mis_exc",      {31'b0, exc},             32'h1);
    chk("mis_exc_addr", exc_addr,                 32'h202);
    chk("mis_en",       {31'b0, bus.enable_out},  32'h0);
    chk("mis_req",      {31'b0, bus.mem_read_en}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      adv; smp;
      chk("mis_pulse",     {31'b0, exc},             32'h0);
      chk("mis_addr_hold", exc_addr,                 32'h202);
      chk("mis_parked",    {31'b0, bus.mem_read_en}, 32'h0);
    end

    // aligned redirect to 0x10, then a jump on the same cycle as the handshake
    adv; jump_en = 1'b1; jump_addr = 32'h10; smp;
    adv; jump_en = 1'b0; smp;
    chk("j10_req",  {31'b0, bus.mem_read_en}, 32'h1);
    chk("j10_addr", {2'b00, bus.mem_addr},    32'h4);
    adv; smp;
    adv; jump_en = 1'b1; jump_addr = 32'h40; smp;
    chk("j10_pc", bus.PC_out, 32'h10);
    chk("j10_ir", bus.IR_out, 32'hA500_0004);
    adv; jump_en = 1'b0; smp;
    chk("hsj_en",   {31'b0, bus.enable_out}, 32'h0);
    chk("hsj_addr", {2'b00, bus.mem_addr},   32'h10);
    adv; smp;
    adv; jump_en = 1'b1; jump_addr = 32'hFFFF_FFFC; smp;
    chk("hsj_pc", bus.PC_out, 32'h40);
    chk("hsj_ir", bus.IR_out, 32'hA500_0010);

    // PC wraps from 0xFFFF_FFFC to 0
    adv; jump_en = 1'b0; smp;
    chk("top_addr", {2'b00, bus.mem_addr}, 32'h3FFF_FFFF);
    adv; smp;
    adv; smp;
    chk("top_pc", bus.PC_out, 32'hFFFF_FFFC);
    chk("top_ir", bus.IR_out, 32'h9AFF_FFFF);
    adv; lat = 4; smp;
    chk("wrap_req",  {31'b0, bus.mem_read_en}, 32'h1);
    chk("wrap_addr", {2'b00, bus.mem_addr},    32'h0);

    // asynchronous reset in the middle of an outstanding read
    adv; smp;
    adv; reset_n = 1'b0; fetch_enable = 1'b0; smp;
    chk("ar_en",   {31'b0, bus.enable_out},  32'h0);
    chk("ar_req",  {31'b0, bus.mem_read_en}, 32'h0);
    chk("ar_ir",   bus.IR_out,               32'h0);
    chk("ar_pc",   bus.PC_out,               32'h0);
    chk("ar_exca", exc_addr,                 32'h0);
    adv; smp;
    adv; reset_n = 1'b1; smp;
    for (int k = 0; k < 3; k++) begin
      adv; smp;
      chk("late_ack_en",   {31'b0, bus.enable_out},  32'h0);
      chk("late_ack_req",  {31'b0, bus.mem_read_en}, 32'h0);
      chk("late_ack_addr", {2'b00, bus.mem_addr},    32'h0);
    end
    adv; fetch_enable = 1'b1; smp;
    chk("idle_req", {31'b0, bus.mem_read_en}, 32'h0);
    adv; smp;
    chk("rstpc_req",  {31'b0, bus.mem_read_en}, 32'h1);
    chk("rstpc_addr", {2'b00, bus.mem_addr},    32'h0);
    for (int k = 0; k < 4; k++) begin
      adv; smp;
    end
    adv; smp;
    chk("rstpc_en", {31'b0, bus.enable_out}, 32'h1);
    chk("rstpc_pc", bus.PC_out,              32'h0);
    chk("rstpc_ir", bus.IR_out,              32'hA500_0000);

    // synchronous reset clears the decode outputs
    adv; sync_reset = 1'b1; smp;
    adv; sync_reset = 1'b0; smp;
    chk("sr_en", {31'b0, bus.enable_out}, 32'h0);
    chk("sr_pc", bus.PC_out,              32'h0);
    chk("sr_ir", bus.IR_out,              32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
